// File: rtl/reg_read_pkg.sv
// rtl/reg_read_pkg.sv - shared types and defaults for the register-read stage
package reg_read_pkg;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_AREG_W  = 3;
    localparam int DEF_NUM_FWD = 2;
    localparam int SCALE_W     = 2;

    typedef enum logic {
        OPER = 1'b0,
        AGEN = 1'b1
    } state_e;

endpackage

// File: rtl/reg_read_mp_fwd_select.sv
// rtl/reg_read_mp_fwd_select.sv - writeback bypass mux for one register read
module fwd_select
    import reg_read_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int AREG_W  = DEF_AREG_W,
    parameter int NUM_FWD = DEF_NUM_FWD
) (
    input  logic [AREG_W-1:0]         tag_i,
    input  logic [DATA_W-1:0]         rf_data_i,
    input  logic [NUM_FWD-1:0]        wb_v_i,
    input  logic [NUM_FWD*AREG_W-1:0] wb_tag_i,
    input  logic [NUM_FWD*DATA_W-1:0] wb_data_i,
    output logic [DATA_W-1:0]         data_o
);

    // Walk buses from highest to lowest so the lowest-numbered hit is written last and wins
    always_comb begin
        data_o = rf_data_i;
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (wb_v_i[k] && (wb_tag_i[k*AREG_W +: AREG_W] == tag_i)) begin
                data_o = wb_data_i[k*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/reg_read_mp.sv
// rtl/reg_read_mp.sv - two-port register read with address generation
module reg_read_mp
    import reg_read_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int AREG_W  = DEF_AREG_W,
    parameter int NUM_FWD = DEF_NUM_FWD
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_v,
    output logic                      in_rdy,
    input  logic                      in_s1_en,
    input  logic                      in_s2_en,
    input  logic                      in_base_en,
    input  logic                      in_idx_en,
    input  logic [AREG_W-1:0]         in_s1,
    input  logic [AREG_W-1:0]         in_s2,
    input  logic [AREG_W-1:0]         in_base,
    input  logic [AREG_W-1:0]         in_idx,
    input  logic [SCALE_W-1:0]        in_scale,
    input  logic [DATA_W-1:0]         in_disp,
    output logic [AREG_W-1:0]         rf_ra0,
    output logic [AREG_W-1:0]         rf_ra1,
    input  logic [DATA_W-1:0]         rf_rd0,
    input  logic [DATA_W-1:0]         rf_rd1,
    input  logic [NUM_FWD-1:0]        wb_v,
    input  logic [NUM_FWD*AREG_W-1:0] wb_tag,
    input  logic [NUM_FWD*DATA_W-1:0] wb_data,
    input  logic                      dep,
    input  logic                      flush,
    output logic                      out_v,
    input  logic                      out_rdy,
    output logic [DATA_W-1:0]         out_src1,
    output logic [DATA_W-1:0]         out_src2,
    output logic [DATA_W-1:0]         out_addr
);

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  addr_q, addr_d;
    logic               out_v_q, out_v_d;
    logic [DATA_W-1:0]  out_src1_q, out_src1_d;
    logic [DATA_W-1:0]  out_src2_q, out_src2_d;
    logic [DATA_W-1:0]  out_addr_q, out_addr_d;

    logic               two_phase;
    logic               advance;
    logic               load;
    logic [DATA_W-1:0]  s1_val, s2_val, base_val, idx_val;
    logic [DATA_W-1:0]  addr_calc;

    // Memory operands need both ports when a source is also read, so those take two passes
    assign two_phase = in_base_en & in_idx_en & (in_s1_en | in_s2_en);
    assign advance   = in_v & ~dep & ~flush & (~out_v_q | out_rdy);

    // Port steering: sources in AGEN, base/idx for two-phase OPER, otherwise sources with base/idx fallback
    always_comb begin
        rf_ra0 = in_s1_en ? in_s1 : in_base;
        rf_ra1 = in_s2_en ? in_s2 : in_idx;
        if (state_q == AGEN) begin
            rf_ra0 = in_s1;
            rf_ra1 = in_s2;
        end else if (two_phase) begin
            rf_ra0 = in_base;
            rf_ra1 = in_idx;
        end
    end

    // Single-phase address operands come off the same ports as the sources, so base/idx follow rf_ra*
    fwd_select #(.DATA_W(DATA_W), .AREG_W(AREG_W), .NUM_FWD(NUM_FWD)) u_fwd_s1 (
        .tag_i(in_s1), .rf_data_i(rf_rd0), .wb_v_i(wb_v), .wb_tag_i(wb_tag), .wb_data_i(wb_data), .data_o(s1_val)
    );
    fwd_select #(.DATA_W(DATA_W), .AREG_W(AREG_W), .NUM_FWD(NUM_FWD)) u_fwd_s2 (
        .tag_i(in_s2), .rf_data_i(rf_rd1), .wb_v_i(wb_v), .wb_tag_i(wb_tag), .wb_data_i(wb_data), .data_o(s2_val)
    );
    fwd_select #(.DATA_W(DATA_W), .AREG_W(AREG_W), .NUM_FWD(NUM_FWD)) u_fwd_base (
        .tag_i(rf_ra0), .rf_data_i(rf_rd0), .wb_v_i(wb_v), .wb_tag_i(wb_tag), .wb_data_i(wb_data), .data_o(base_val)
    );
    fwd_select #(.DATA_W(DATA_W), .AREG_W(AREG_W), .NUM_FWD(NUM_FWD)) u_fwd_idx (
        .tag_i(rf_ra1), .rf_data_i(rf_rd1), .wb_v_i(wb_v), .wb_tag_i(wb_tag), .wb_data_i(wb_data), .data_o(idx_val)
    );

    assign addr_calc = (in_base_en ? base_val : '0)
                     + ((in_idx_en ? idx_val : '0) << in_scale)
                     + in_disp;

    // Next-state, handshake and output-register load decisions
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        out_v_d    = out_v_q;
        out_src1_d = out_src1_q;
        out_src2_d = out_src2_q;
        out_addr_d = out_addr_q;
        in_rdy     = 1'b0;
        load       = 1'b0;

        if (advance && !rst) begin
            if (state_q == AGEN) begin
                in_rdy     = 1'b1;
                load       = 1'b1;
                out_addr_d = addr_q;
                state_d    = OPER;
            end else if (two_phase) begin
                addr_d  = addr_calc;
                state_d = AGEN;
            end else begin
                in_rdy     = 1'b1;
                load       = 1'b1;
                out_addr_d = addr_calc;
            end
        end

        if (load) begin
            out_v_d    = 1'b1;
            out_src1_d = in_s1_en ? s1_val : '0;
            out_src2_d = in_s2_en ? s2_val : '0;
        end else if (out_rdy) begin
            out_v_d = 1'b0;
        end

        if (flush) begin
            state_d = OPER;
            out_v_d = 1'b0;
        end
    end

    // State, captured address and output register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= OPER;
            addr_q     <= '0;
            out_v_q    <= 1'b0;
            out_src1_q <= '0;
            out_src2_q <= '0;
            out_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            out_v_q    <= out_v_d;
            out_src1_q <= out_src1_d;
            out_src2_q <= out_src2_d;
            out_addr_q <= out_addr_d;
        end
    end

    assign out_v    = out_v_q;
    assign out_src1 = out_src1_q;
    assign out_src2 = out_src2_q;
    assign out_addr = out_addr_q;

endmodule

// File: tb/tb_reg_read_mp.sv
// tb/tb_reg_read_mp.sv - self-checking bench for reg_read_mp
module tb_reg_read_mp;

    localparam int DW = 32;
    localparam int AW = 3;
    localparam int NF = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst, in_v, in_rdy;
    logic           in_s1_en, in_s2_en, in_base_en, in_idx_en;
    logic [AW-1:0]  in_s1, in_s2, in_base, in_idx;
    logic [1:0]     in_scale;
    logic [DW-1:0]  in_disp;
    logic [AW-1:0]  rf_ra0, rf_ra1;
    logic [DW-1:0]  rf_rd0, rf_rd1;
    logic [NF-1:0]  wb_v;
    logic [NF*AW-1:0] wb_tag;
    logic [NF*DW-1:0] wb_data;
    logic           dep, flush, out_v, out_rdy;
    logic [DW-1:0]  out_src1, out_src2, out_addr;

    logic [DW-1:0]  rf_mem [8];
    assign rf_rd0 = rf_mem[rf_ra0];
    assign rf_rd1 = rf_mem[rf_ra1];

    reg_read_mp #(.DATA_W(DW), .AREG_W(AW), .NUM_FWD(NF)) dut (
        .clk(clk), .rst(rst), .in_v(in_v), .in_rdy(in_rdy),
        .in_s1_en(in_s1_en), .in_s2_en(in_s2_en), .in_base_en(in_base_en), .in_idx_en(in_idx_en),
        .in_s1(in_s1), .in_s2(in_s2), .in_base(in_base), .in_idx(in_idx),
        .in_scale(in_scale), .in_disp(in_disp),
        .rf_ra0(rf_ra0), .rf_ra1(rf_ra1), .rf_rd0(rf_rd0), .rf_rd1(rf_rd1),
        .wb_v(wb_v), .wb_tag(wb_tag), .wb_data(wb_data),
        .dep(dep), .flush(flush),
        .out_v(out_v), .out_rdy(out_rdy),
        .out_src1(out_src1), .out_src2(out_src2), .out_addr(out_addr)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Value a read of register tag must return: first valid matching bus, else the register file
    function automatic logic [31:0] rd(input logic [AW-1:0] tag);
        for (int k = 0; k < NF; k++)
            if (wb_v[k] && wb_tag[k*AW +: AW] == tag) return wb_data[k*DW +: DW];
        return rf_mem[tag];
    endfunction

    bit          armed = 1'b0, m_agen = 1'b0, m_ov = 1'b0, last_rdy = 1'b0, last_kill = 1'b0;
    logic [31:0] m_addr = '0, m_s1 = '0, m_s2 = '0, m_a = '0;

    // Reference model: per-instruction pass count, captured address and a one-entry output slot
    always @(negedge clk) begin : cmp
        bit          two, go, ld;
        logic [31:0] a;
        logic [AW-1:0] ea0, ea1;
        two = in_base_en && in_idx_en && (in_s1_en || in_s2_en);
        go  = in_v && !dep && !flush && !rst && (!m_ov || out_rdy);
        if (m_agen)   begin ea0 = in_s1;   ea1 = in_s2;  end
        else if (two) begin ea0 = in_base; ea1 = in_idx; end
        else begin
            ea0 = in_s1_en ? in_s1 : in_base;
            ea1 = in_s2_en ? in_s2 : in_idx;
        end
        a = (in_base_en ? rd(in_base) : 32'h0)
          + ((in_idx_en ? rd(in_idx) : 32'h0) * (32'h1 << in_scale))
          + in_disp;
        if (armed) begin
            chk("out_v", 32'(out_v), 32'(m_ov));
            chk("out_src1", out_src1, m_s1);
            chk("out_src2", out_src2, m_s2);
            chk("out_addr", out_addr, m_a);
            chk("in_rdy", 32'(in_rdy), 32'(go && (m_agen || !two)));
            chk("rf_ra0", 32'(rf_ra0), 32'(ea0));
            chk("rf_ra1", 32'(rf_ra1), 32'(ea1));
        end
        last_rdy  = go && (m_agen || !two);
        last_kill = rst || flush;
        if (rst) begin
            armed = 1'b1; m_agen = 1'b0; m_ov = 1'b0;
            m_addr = '0; m_s1 = '0; m_s2 = '0; m_a = '0;
        end else if (flush) begin
            m_agen = 1'b0; m_ov = 1'b0;
        end else begin
            ld = 1'b0;
            if (go) begin
                if (m_agen)   begin ld = 1'b1; m_a = m_addr; m_agen = 1'b0; end
                else if (two) begin m_addr = a; m_agen = 1'b1; end
                else          begin ld = 1'b1; m_a = a; end
            end
            if (ld) begin
                m_ov = 1'b1;
                m_s1 = in_s1_en ? rd(in_s1) : 32'h0;
                m_s2 = in_s2_en ? rd(in_s2) : 32'h0;
            end else if (out_rdy) begin
                m_ov = 1'b0;
            end
        end
    end

    task automatic idle();
        in_v = 0; in_s1_en = 0; in_s2_en = 0; in_base_en = 0; in_idx_en = 0;
        in_s1 = 0; in_s2 = 0; in_base = 0; in_idx = 0; in_scale = 0; in_disp = 0;
        wb_v = 0; wb_tag = 0; wb_data = 0; dep = 0; flush = 0; out_rdy = 1;
    endtask

    task automatic ins(input bit s1e, input logic [AW-1:0] s1, input bit s2e, input logic [AW-1:0] s2,
                       input bit be, input logic [AW-1:0] b, input bit ie, input logic [AW-1:0] ix,
                       input logic [1:0] sc, input logic [31:0] d);
        in_v = 1; in_s1_en = s1e; in_s1 = s1; in_s2_en = s2e; in_s2 = s2;
        in_base_en = be; in_base = b; in_idx_en = ie; in_idx = ix; in_scale = sc; in_disp = d;
    endtask

    task automatic new_instr();
        in_v = ($urandom % 4) != 0;
        in_s1_en = 1'($urandom); in_s2_en = 1'($urandom);
        in_base_en = 1'($urandom); in_idx_en = 1'($urandom);
        in_s1 = 3'($urandom); in_s2 = 3'($urandom); in_base = 3'($urandom); in_idx = 3'($urandom);
        in_scale = 2'($urandom); in_disp = $urandom;
        if (!(in_base_en && in_idx_en && (in_s1_en || in_s2_en))) begin
            if (in_s1_en && in_base_en) in_base = in_s1;
            if (in_s2_en && in_idx_en) in_idx = in_s2;
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) rf_mem[i] = 32'h0;
        idle();
        rst = 1;
        ins(1, 3'd2, 0, 3'd0, 0, 3'd0, 0, 3'd0, 2'd0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("rst in_rdy", 32'(in_rdy), 32'h0);
        chk("rst out_v", 32'(out_v), 32'h0);
        chk("rst out_addr", out_addr, 32'h0);
        @(posedge clk); #2; rst = 0; idle();

        // single-phase, latency 1
        @(posedge clk); #2;
        rf_mem[2] = 32'h10; rf_mem[3] = 32'h20;
        ins(1, 3'd2, 1, 3'd3, 1, 3'd2, 0, 3'd0, 2'd0, 32'h100);
        @(negedge clk); #1; chk("A in_rdy", 32'(in_rdy), 32'h1);
        @(posedge clk); #2; in_v = 0;
        @(negedge clk); #1;
        chk("A out_v", 32'(out_v), 32'h1);
        chk("A src1", out_src1, 32'h10);
        chk("A src2", out_src2, 32'h20);
        chk("A addr", out_addr, 32'h110);

        // two-phase, latency 2
        @(posedge clk); #2;
        rf_mem[1] = 32'h1000; rf_mem[2] = 32'h4; rf_mem[3] = 32'h7;
        ins(1, 3'd3, 0, 3'd0, 1, 3'd1, 1, 3'd2, 2'd2, 32'hFFFFFFF8);
        @(negedge clk); #1; chk("B in_rdy c1", 32'(in_rdy), 32'h0);
        @(negedge clk); #1; chk("B in_rdy c2", 32'(in_rdy), 32'h1);
        chk("B out_v c2", 32'(out_v), 32'h0);
        @(posedge clk); #2; in_v = 0;
        @(negedge clk); #1;
        chk("B out_v", 32'(out_v), 32'h1);
        chk("B addr", out_addr, 32'h1008);
        chk("B src1", out_src1, 32'h7);
        chk("B src2", out_src2, 32'h0);

        // forwarding priority
        @(posedge clk); #2;
        rf_mem[2] = 32'h11;
        ins(1, 3'd2, 0, 3'd0, 0, 3'd0, 0, 3'd0, 2'd0, 32'h0);
        wb_v = 2'b11; wb_tag = {3'd2, 3'd2}; wb_data = {32'hBB, 32'hAA};
        @(negedge clk); #1; chk("C in_rdy", 32'(in_rdy), 32'h1);
        @(posedge clk); #2; wb_v = 2'b10;
        @(negedge clk); #1; chk("C src1 wb0", out_src1, 32'hAA);
        @(posedge clk); #2; in_v = 0; wb_v = 2'b00;
        @(negedge clk); #1; chk("C src1 wb1", out_src1, 32'hBB);
        chk("C addr", out_addr, 32'h0);

        // output backpressure
        @(posedge clk); #2;
        rf_mem[4] = 32'h44; rf_mem[5] = 32'h55; out_rdy = 0;
        ins(1, 3'd4, 0, 3'd0, 0, 3'd0, 0, 3'd0, 2'd0, 32'h0);
        @(negedge clk); #1; chk("D in_rdy", 32'(in_rdy), 32'h1);
        @(posedge clk); #2; in_s1 = 3'd5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("D stall out_v", 32'(out_v), 32'h1);
            chk("D stall src1", out_src1, 32'h44);
            chk("D stall in_rdy", 32'(in_rdy), 32'h0);
            @(posedge clk); #2;
        end
        out_rdy = 1;
        @(negedge clk); #1;
        chk("D release in_rdy", 32'(in_rdy), 32'h1);
        chk("D release src1", out_src1, 32'h44);
        @(posedge clk); #2; in_v = 0;
        @(negedge clk); #1;
        chk("D next src1", out_src1, 32'h55);
        chk("D next out_v", 32'(out_v), 32'h1);

        // dep in AGEN with base register changing
        @(posedge clk); #2;
        rf_mem[1] = 32'h1000; rf_mem[2] = 32'h4;
        ins(1, 3'd3, 0, 3'd0, 1, 3'd1, 1, 3'd2, 2'd0, 32'h0);
        @(negedge clk); #1; chk("E in_rdy c1", 32'(in_rdy), 32'h0);
        @(posedge clk); #2;
        dep = 1; rf_mem[1] = 32'h5000;
        wb_v = 2'b01; wb_tag = {3'd0, 3'd1}; wb_data = {32'h0, 32'h9000};
        @(negedge clk); #1; chk("E dep in_rdy 1", 32'(in_rdy), 32'h0);
        @(negedge clk); #1; chk("E dep in_rdy 2", 32'(in_rdy), 32'h0);
        @(posedge clk); #2; dep = 0; wb_v = 2'b00;
        @(negedge clk); #1; chk("E in_rdy", 32'(in_rdy), 32'h1);
        @(posedge clk); #2; in_v = 0;
        @(negedge clk); #1;
        chk("E addr", out_addr, 32'h1004);
        chk("E out_v", 32'(out_v), 32'h1);

        // flush in AGEN, then reset in AGEN
        @(posedge clk); #2;
        ins(1, 3'd3, 0, 3'd0, 1, 3'd1, 1, 3'd2, 2'd0, 32'h0);
        @(posedge clk); #2; flush = 1;
        @(negedge clk); #1; chk("F flush in_rdy", 32'(in_rdy), 32'h0);
        @(posedge clk); #2; flush = 0;
        @(negedge clk); #1;
        chk("F out_v", 32'(out_v), 32'h0);
        chk("F back in OPER", 32'(in_rdy), 32'h0);
        @(posedge clk); #2; rst = 1;
        @(negedge clk); #1; chk("F rst in_rdy", 32'(in_rdy), 32'h0);
        @(posedge clk); #2; rst = 0; in_v = 0;
        @(negedge clk); #1;
        chk("F rst out_v", 32'(out_v), 32'h0);
        chk("F rst addr", out_addr, 32'h0);
        chk("F rst src1", out_src1, 32'h0);
        @(negedge clk); #1; chk("F no stale out_v", 32'(out_v), 32'h0);

        // randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #2;
            rst = 0;
            if (!in_v || last_rdy || last_kill) new_instr();
            dep     = ($urandom % 5) == 0;
            flush   = ($urandom % 40) == 0;
            rst     = ($urandom % 97) == 0;
            out_rdy = ($urandom % 4) != 0;
            wb_v    = 2'($urandom);
            wb_tag  = 6'($urandom);
            wb_data = {$urandom, $urandom};
            rf_mem[$urandom % 8] = $urandom;
        end
        @(posedge clk); #2; idle(); rst = 0;
        @(negedge clk); #2;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
